decoder_seq_ctrl: RTL and testbench
===================================

// Module: decoder_seq_ctrl
// PURPOSE
// - Sequencer for the 1024-bit pattern decoder (PROGRAM SIPO + SIGNAL SIPO + equality comparator).
// - Per start command: clears both decoder registers, shifts in exactly N pattern bits over a
//   valid/ready stream, then arms and counts cycles where the decoder match output is high.
// - Sits between the host/config logic and the decoder; owns the decoder clr/enable/prgm pins.
// PARAMETERS
// - N      1024  pattern length in bits; must equal decoder register width; N >= 2
// - CNT_W  16    match counter width; saturating
// PORTS
// - clk          in   1      rising-edge clock, shared with the decoder
// - clr_n        in   1      reset, asynchronous, active-low
// - start        in   1      1-cycle command: (re)program and arm; ignored in CLEAR
// - abort        in   1      return to IDLE from any state; has priority over start
// - prog_bit     in   1      next pattern bit, first bit sent = oldest bit in the register
// - prog_valid   in   1      prog_bit valid
// - prog_ready   out  1      controller accepts prog_bit this cycle
// - dec_clr      out  1      decoder clear, active-high, 1-cycle pulse
// - dec_enable   out  1      decoder PROGRAM shift enable
// - dec_prgm     out  1      decoder PROGRAM serial data
// - dec_match    in   1      decoder equality output
// - busy         out  1      high in CLEAR or LOAD
// - armed        out  1      high in ARMED
// - match_pulse  out  1      registered: 1 cycle after each ARMED cycle with dec_match=1
// - match_count  out  CNT_W  number of ARMED cycles with dec_match=1 since last start
// - overflow     out  1      sticky: match_count saturated
// BEHAVIOUR
// - Reset (clr_n=0, async): state=IDLE; prog_ready, dec_clr, dec_enable, dec_prgm, busy,
//   armed, match_pulse, overflow = 0; match_count = 0; bit counter = 0.
// - Reset mid-operation: same values immediately; no partial load resumes.
// - FSM states: IDLE, CLEAR, LOAD, ARMED.
// - IDLE:  start=1 -> CLEAR. All outputs held; match_count/overflow retain last value.
// - CLEAR: exactly 1 cycle; dec_clr=1. Zero match_count, overflow, bit counter. -> LOAD.
// - LOAD:  prog_ready=1. Handshake = prog_valid & prog_ready.
//   - dec_enable = handshake, combinational.
//   - dec_prgm = prog_bit, combinational.
//   - Bit counter (width clog2(N)) increments per handshake.
//   - Handshake with counter==N-1 -> ARMED next cycle; counter returns to 0.
//   - prog_valid low: stall; decoder PROGRAM holds; no timeout.
// - ARMED: prog_ready=0, dec_enable=0.
//   - Each cycle with dec_match=1: match_count += 1, saturating at 2^CNT_W-1.
//   - Increment attempted at max: overflow=1.
//   - match_pulse = dec_match registered.
//   - Stays ARMED until start (-> CLEAR) or abort.
// - abort=1 in any state -> IDLE next cycle; dec_clr=1 that cycle.
//   - Abort during LOAD discards the partial pattern. match_count is retained.
// - start in LOAD: restarts via CLEAR. start in CLEAR: ignored.
// - start and abort in the same cycle: abort wins.
// - Match is never counted before ARMED. The SIGNAL register shifts every cycle from CLEAR,
//   and LOAD lasts >= N cycles, so both registers hold post-clear data at ARMED entry.
//   Zero-vs-zero after clear cannot be counted.
// - Minimum start -> armed latency: N+1 cycles (1 CLEAR + N LOAD with prog_valid held high).
// - dec_match is used only in ARMED; no other input affects match_count.
// TESTING
// - Reset: clr_n low mid-LOAD at bit 500 -> all outputs 0 asynchronously; IDLE after release.
// - Program N=1024 bits with prog_valid always high ->
//   - dec_clr high exactly 1 cycle, then 1024 dec_enable cycles.
//   - armed rises 1025 cycles after start; busy is low at the same time.
// - Stalls: drop prog_valid for 3 cycles every 100 bits -> dec_enable count still 1024;
//   armed only after the 1024th handshake.
// - Counting: ARMED with dec_match forced high 5 cycles, low 2, high 1 -> match_count=6;
//   match_pulse shows the same pattern delayed 1 cycle.
// - Saturation: CNT_W=4, dec_match high 20 ARMED cycles -> match_count=15, overflow=1;
//   then start -> both 0 after CLEAR.
// - Abort/priority: abort+start same cycle in LOAD -> IDLE, dec_clr 1 cycle, no CLEAR state;
//   dec_match=1 in IDLE -> count unchanged.

Source files
------------

// File: rtl/decoder_seq_ctrl.sv
// Sequencer for the N-bit pattern decoder: clears the decoder, streams N pattern bits into
// its PROGRAM register over a valid/ready handshake, then counts matches while armed.
module decoder_seq_ctrl #(
  parameter int N     = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             abort,
  input  logic             prog_bit,
  input  logic             prog_valid,
  output logic             prog_ready,
  output logic             dec_clr,
  output logic             dec_enable,
  output logic             dec_prgm,
  input  logic             dec_match,
  output logic             busy,
  output logic             armed,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

  localparam int               BIT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    ARMED
  } state_t;

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic             handshake;

  // prog_ready is a registered copy of (state == LOAD), so the decoder pins follow it directly.
  assign handshake  = prog_valid & prog_ready;
  assign dec_enable = handshake;
  assign dec_prgm   = prog_ready & prog_bit;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      prog_ready  <= 1'b0;
      dec_clr     <= 1'b0;
      busy        <= 1'b0;
      armed       <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      dec_clr     <= 1'b0;
      match_pulse <= 1'b0;

      // Matches only count while armed; the count saturates and latches overflow.
      if (state == ARMED && dec_match) begin
        match_pulse <= 1'b1;
        if (match_count == CNT_MAX) begin
          overflow <= 1'b1;
        end else begin
          match_count <= match_count + CNT_ONE;
        end
      end

      if (abort) begin
        state      <= IDLE;
        dec_clr    <= 1'b1;
        prog_ready <= 1'b0;
        busy       <= 1'b0;
        armed      <= 1'b0;
        bit_cnt    <= '0;
      end else if (start && state != CLEAR) begin
        // Counter and overflow read zero for the whole CLEAR cycle.
        state       <= CLEAR;
        dec_clr     <= 1'b1;
        prog_ready  <= 1'b0;
        busy        <= 1'b1;
        armed       <= 1'b0;
        bit_cnt     <= '0;
        match_count <= '0;
        overflow    <= 1'b0;
      end else begin
        case (state)
          CLEAR: begin
            state      <= LOAD;
            prog_ready <= 1'b1;
          end
          LOAD: begin
            if (handshake) begin
              if (bit_cnt == LAST_BIT) begin
                state      <= ARMED;
                bit_cnt    <= '0;
                prog_ready <= 1'b0;
                busy       <= 1'b0;
                armed      <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BIT_ONE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_seq_ctrl.sv
// Scoreboard bench for decoder_seq_ctrl: a driver issues commands and pushes expected events,
// a negedge monitor pops and compares whenever the DUT presents dec_clr, dec_enable, armed or match_pulse.
module tb_decoder_seq_ctrl;

  localparam int N       = 1024;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             prog_bit = 1'b0;
  logic             prog_valid = 1'b0;
  logic             dec_match = 1'b0;
  logic             prog_ready;
  logic             dec_clr;
  logic             dec_enable;
  logic             dec_prgm;
  logic             busy;
  logic             armed;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             overflow;

  decoder_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .abort      (abort),
    .prog_bit   (prog_bit),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .dec_clr    (dec_clr),
    .dec_enable (dec_enable),
    .dec_prgm   (dec_prgm),
    .dec_match  (dec_match),
    .busy       (busy),
    .armed      (armed),
    .match_pulse(match_pulse),
    .match_count(match_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {int cyc; bit busy;} clr_t;
  typedef struct {int cyc; int n_en;} arm_t;
  typedef struct {int cyc; int cnt; bit ovf;} mt_t;

  clr_t clr_q[$];
  arm_t arm_q[$];
  mt_t  m_q[$];
  bit   bit_q[$];

  // Reference model of the match counter: saturating count plus sticky overflow.
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event at cycle %0d, none expected", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    int  en_cnt = 0;
    bit  prev_armed = 1'b0;
    clr_t ce;
    arm_t ae;
    mt_t  me;
    forever begin
      @(negedge clk);
      if (clr_n) begin
        if (dec_clr) begin
          if (clr_q.size() == 0) unexpected("dec_clr");
          else begin
            ce = clr_q.pop_front();
            check("dec_clr_cycle", cyc, ce.cyc);
            check("busy_at_clr", busy, ce.busy);
          end
          en_cnt = 0;
        end
        if (dec_enable) begin
          en_cnt++;
          if (bit_q.size() == 0) unexpected("dec_enable");
          else check("dec_prgm", dec_prgm, bit_q.pop_front());
        end
        if (armed && !prev_armed) begin
          if (arm_q.size() == 0) unexpected("armed_rise");
          else begin
            ae = arm_q.pop_front();
            check("arm_cycle", cyc, ae.cyc);
            check("arm_enable_count", en_cnt, ae.n_en);
            check("busy_at_arm", busy, 0);
          end
        end
        prev_armed = armed;
        if (match_pulse) begin
          if (m_q.size() == 0) unexpected("match_pulse");
          else begin
            me = m_q.pop_front();
            check("match_pulse_cycle", cyc, me.cyc);
            check("match_count", match_count, me.cnt);
            check("overflow", overflow, me.ovf);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_prog_ready"}, prog_ready, 0);
    check({tag, "_dec_clr"}, dec_clr, 0);
    check({tag, "_dec_enable"}, dec_enable, 0);
    check({tag, "_dec_prgm"}, dec_prgm, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_armed"}, armed, 0);
    check({tag, "_match_pulse"}, match_pulse, 0);
    check({tag, "_match_count"}, match_count, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  // Issued from IDLE, LOAD or ARMED; returns in the CLEAR cycle.
  task automatic issue_start();
    start     = 1'b1;
    dec_match = 1'b0;
    clr_q.push_back(clr_t'{cyc + 1, 1'b1});
    m_cnt = 0;
    m_ovf = 1'b0;
    tick();
    start = 1'b0;
    check("clear_count_zero", match_count, 0);
    check("clear_overflow_zero", overflow, 0);
  endtask

  // Called in the CLEAR cycle. stall_mode: 0 none, 1 three cycles every 100 bits, 2 random.
  task automatic load_bits(input int nbits, input int stall_mode);
    int stalls;
    int c_clear;
    int ns;
    stalls  = 0;
    c_clear = cyc;
    dec_match = 1'($urandom);
    tick();
    for (int i = 0; i < nbits; i++) begin
      ns = 0;
      if (stall_mode == 1 && i > 0 && (i % 100) == 0) ns = 3;
      else if (stall_mode == 2 && $urandom_range(0, 15) == 0) ns = int'($urandom_range(1, 4));
      repeat (ns) begin
        prog_valid = 1'b0;
        prog_bit   = 1'($urandom);
        dec_match  = 1'($urandom);
        tick();
      end
      stalls += ns;
      prog_valid = 1'b1;
      prog_bit   = 1'($urandom);
      dec_match  = 1'($urandom);
      bit_q.push_back(prog_bit);
      tick();
    end
    prog_valid = 1'b0;
    dec_match  = 1'b0;
    if (nbits == N) arm_q.push_back(arm_t'{c_clear + N + 1 + stalls, N});
  endtask

  // One ARMED cycle with the given dec_match value.
  task automatic run_match(input bit v);
    dec_match = v;
    if (v) begin
      if (m_cnt == CNT_MAX) m_ovf = 1'b1;
      else m_cnt++;
      m_q.push_back(mt_t'{cyc + 1, m_cnt, m_ovf});
    end
    tick();
    dec_match = 1'b0;
  endtask

  task automatic do_abort();
    abort     = 1'b1;
    dec_match = 1'b0;
    clr_q.push_back(clr_t'{cyc + 1, 1'b0});
    tick();
    abort = 1'b0;
  endtask

  initial begin
    // Reset held from time zero with inputs active
    prog_valid = 1'b1;
    prog_bit   = 1'b1;
    tick();
    tick();
    check_all_zero("por");
    prog_valid = 1'b0;
    prog_bit   = 1'b0;
    clr_n      = 1'b1;
    tick();

    // Asynchronous reset in the middle of a load
    issue_start();
    load_bits(500, 0);
    check("midload_busy", busy, 1);
    check("midload_ready", prog_ready, 1);
    #2 clr_n = 1'b0;
    #1;
    prog_valid = 1'b1;
    prog_bit   = 1'b1;
    #1;
    check_all_zero("async_rst");
    prog_valid = 1'b0;
    prog_bit   = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_armed", armed, 0);
    check("post_rst_ready", prog_ready, 0);

    // Full program with prog_valid held high
    issue_start();
    load_bits(N, 0);
    check("armed_after_load", armed, 1);
    check("ready_in_armed", prog_ready, 0);

    // Counting pattern: 5 high, 2 low, 1 high
    for (int i = 0; i < 5; i++) run_match(1'b1);
    run_match(1'b0);
    run_match(1'b0);
    run_match(1'b1);
    check("count_pattern", match_count, 6);
    tick();

    // Abort from ARMED keeps the count; dec_match in IDLE does nothing
    do_abort();
    check("abort_armed_low", armed, 0);
    check("abort_busy_low", busy, 0);
    check("abort_keeps_count", match_count, m_cnt);
    dec_match = 1'b1;
    repeat (5) tick();
    dec_match = 1'b0;
    tick();
    check("idle_count_unchanged", match_count, 6);

    // Program with periodic stalls
    issue_start();
    load_bits(N, 1);
    check("armed_after_stall_load", armed, 1);

    // Saturation, then start clears count and overflow
    repeat (20) run_match(1'b1);
    tick();
    check("sat_count", match_count, CNT_MAX);
    check("sat_overflow", overflow, 1);
    issue_start();
    load_bits(N, 2);

    // Random matching
    for (int i = 0; i < 40; i++) run_match(1'($urandom));
    tick();
    check("rand_count", match_count, m_cnt);
    check("rand_overflow", overflow, m_ovf);

    // abort and start together during LOAD: straight to IDLE, no CLEAR
    issue_start();
    load_bits(300, 2);
    abort = 1'b1;
    start = 1'b1;
    clr_q.push_back(clr_t'{cyc + 1, 1'b0});
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("prio_busy", busy, 0);
    check("prio_ready", prog_ready, 0);
    tick();
    check("prio_busy_next", busy, 0);
    check("prio_count_kept", match_count, m_cnt);

    // Restart during LOAD, then a full randomly stalled load
    issue_start();
    load_bits(200, 0);
    issue_start();
    load_bits(N, 2);
    run_match(1'b1);
    for (int i = 0; i < 10; i++) run_match(1'($urandom));
    tick();
    check("restart_count", match_count, m_cnt);

    // Asynchronous reset while armed with a nonzero count
    #2 clr_n = 1'b0;
    #1;
    check_all_zero("armed_rst");
    m_cnt = 0;
    m_ovf = 1'b0;
    tick();
    clr_n = 1'b1;
    repeat (3) tick();

    check("bit_q_empty", bit_q.size(), 0);
    check("clr_q_empty", clr_q.size(), 0);
    check("arm_q_empty", arm_q.size(), 0);
    check("m_q_empty", m_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
